// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: drives datapath selects/enables and counts retired instructions.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown opcodes and branch funct3 010/011 trap instead of retiring as NOPs.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
    // DECODE   | branch target into ALUOut, dispatch on opcode
    // MEMADR   | rs1 + imm address for load/store
    // MEMREAD  | data read, wait for mem_ready
    // MEMWB    | write read data to rd
    // MEMWRITE | data write, wait for mem_ready
    // EXEC_R   | rs1 op rs2
    // EXEC_I   | rs1 op imm
    // LUI      | 0 + U-imm
    // AUIPC    | OldPC + U-imm
    // ALUWB    | write ALUOut to rd
    // BRANCH   | compare, load PC with target when taken
    // JAL      | PC <= target, ALU forms OldPC+4 link value
    // JALR_ADR | rs1 + imm into ALUOut
    // JALR_JMP | PC <= ALUOut, ALU forms OldPC+4 link value
    // TRAP     | illegal instruction, frozen until reset
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR_ADR, S_JALR_JMP, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_taken;
    logic             w_retire;

    always_comb begin
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = ~lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = ~ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
`ifdef MC_ILLEGAL_TRAP_EN
                    OP_BRANCH:         w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
                    OP_BRANCH:         w_next = S_BRANCH;
`endif
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL, S_JALR_JMP:
                        w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JALR_ADR: w_next = S_JALR_JMP;
            default:    w_next = S_TRAP;
        endcase
    end

    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + 1'b1;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_illegal <= 1'b0;
        else if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign instret = r_instret;

    // Datapath controls decode from the state register; FETCH enables are also held off while in reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_src    = 3'b000;
        result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready & rst_n;
                pc_write   = mem_ready & rst_n;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = w_taken;
            end
            S_JAL, S_JALR_JMP: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, hand sequences and a
// randomized instruction stream checked against a phase-level model of each instruction class.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        zero, lt, ltu, mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_src;
    logic        illegal;
    logic [31:0] instret;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 32'd0;

    function automatic logic [31:0] ov(logic mr, logic mw, logic as, logic ir, logic pw, logic rw,
                                       logic [1:0] a, logic [1:0] b, logic [1:0] aop,
                                       logic [2:0] imm, logic [1:0] rs);
        return {15'd0, mr, mw, as, ir, pw, rw, a, b, aop, imm, rs};
    endfunction

    localparam logic [31:0] E_FETCH_RDY  = ov(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b00,3'b000,2'b10);
    localparam logic [31:0] E_FETCH_WAIT = ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b000,2'b10);
    localparam logic [31:0] E_DECODE     = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b010,2'b00);
    localparam logic [31:0] E_MEMADR_LD  = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_MEMADR_ST  = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b001,2'b00);
    localparam logic [31:0] E_MEMREAD    = ov(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_MEMWB      = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,2'b01);
    localparam logic [31:0] E_MEMWRITE   = ov(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_JALR_ADR   = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_JALR_JMP   = ov(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_ALUWB      = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,2'b00);
    localparam logic [31:0] E_BR_T       = ov(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,3'b000,2'b00);
    localparam logic [31:0] E_BR_NT      = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,3'b000,2'b00);
    localparam logic [31:0] E_ZERO       = 32'd0;

    function automatic logic [31:0] obs();
        return {15'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, imm_src, result_src};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Release reset between edges with mem_ready low so the first active edge keeps FETCH.
    task automatic release_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic z,
                             input logic l, input logic lu);
        op = o; funct3 = f; zero = z; lt = l; ltu = lu;
    endtask

    // Hand-written sequences: per-cycle mem_ready and full expected output vector.
    logic        seq_rdy [16];
    logic [31:0] seq_exp [16];

    task automatic set_c(input int i, input logic r, input logic [31:0] e);
        seq_rdy[i] = r;
        seq_exp[i] = e;
    endtask

    task automatic run_seq(input string name, input int n, input int retired);
        for (int i = 0; i < n; i++) begin
            mem_ready = seq_rdy[i];
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", name, i), obs(), seq_exp[i]);
            next_cycle();
        end
        exp_instret = exp_instret + 32'(retired);
        chk($sformatf("%s_instret", name), instret, exp_instret);
    endtask

    typedef struct {
        logic [6:0] o;
        logic [2:0] f3;
        logic       z, l, lu;
        int         cyc, pcw, rw;
    } vec_t;

    vec_t vt[$];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, pcw = 0, rw = 0;
        bit done = 0;
        set_instr(v.o, v.f3, v.z, v.l, v.lu);
        mem_ready = 1'b1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            pcw += int'(pc_write);
            rw  += int'(reg_write);
            cyc++;
            next_cycle();
            if (instret !== exp_instret) done = 1;
        end
        exp_instret = exp_instret + 32'd1;
        chk_int($sformatf("vec%0d_cycles", idx), cyc, v.cyc);
        chk_int($sformatf("vec%0d_pc_writes", idx), pcw, v.pcw);
        chk_int($sformatf("vec%0d_reg_writes", idx), rw, v.rw);
        chk($sformatf("vec%0d_instret", idx), instret, exp_instret);
    endtask

    // Reference model: each instruction class is a list of phases; memory phases stall on !mem_ready.
    localparam int PH_FETCH = 0, PH_PLAIN = 1, PH_RD = 2, PH_WR = 3, PH_RWB = 4, PH_JMP = 5, PH_BR = 6;

    function automatic logic model_taken(logic [2:0] f, logic z, logic l, logic lu);
        case (f)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_random(input int idx, input logic [6:0] o);
        int ph[$];
        int i = 0, guard = 0;
        logic r, tk;
        logic [2:0] f = 3'($urandom_range(0, 7));
        logic z = 1'($urandom_range(0, 1));
        logic l = 1'($urandom_range(0, 1));
        logic lu = 1'($urandom_range(0, 1));
        logic [31:0] e;
`ifdef MC_ILLEGAL_TRAP_EN
        if (o == OP_BRANCH && f[2:1] == 2'b01) f[2] = 1'b1;
`endif
        set_instr(o, f, z, l, lu);
        tk = model_taken(f, z, l, lu);
        ph.push_back(PH_FETCH);
        ph.push_back(PH_PLAIN);
        case (o)
            OP_LOAD:                 begin ph.push_back(PH_PLAIN); ph.push_back(PH_RD); ph.push_back(PH_RWB); end
            OP_STORE:                begin ph.push_back(PH_PLAIN); ph.push_back(PH_WR); end
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin ph.push_back(PH_PLAIN); ph.push_back(PH_RWB); end
            OP_JAL:                  begin ph.push_back(PH_JMP); ph.push_back(PH_RWB); end
            OP_JALR:                 begin ph.push_back(PH_PLAIN); ph.push_back(PH_JMP); ph.push_back(PH_RWB); end
            OP_BRANCH:               ph.push_back(PH_BR);
            default:                 ;
        endcase
        while (i < ph.size() && guard < 200) begin
            r = ($urandom_range(0, 3) != 0);
            mem_ready = r;
            @(negedge clk);
            case (ph[i])
                PH_FETCH: e = {27'd0, 1'b1, 1'b0, r, r, 1'b0};
                PH_RD:    e = {27'd0, 5'b10000};
                PH_WR:    e = {27'd0, 5'b11000};
                PH_RWB:   e = {27'd0, 5'b00001};
                PH_JMP:   e = {27'd0, 5'b00010};
                PH_BR:    e = {27'd0, 3'b000, tk, 1'b0};
                default:  e = 32'd0;
            endcase
            chk($sformatf("rnd%0d_op%b_ph%0d", idx, o, i),
                {27'd0, mem_req, mem_write, ir_write, pc_write, reg_write}, e);
            next_cycle();
            if (!((ph[i] == PH_FETCH || ph[i] == PH_RD || ph[i] == PH_WR) && !r)) i++;
            guard++;
        end
        chk_int($sformatf("rnd%0d_timeout", idx), guard < 200 ? 1 : 0, 1);
        exp_instret = exp_instret + 32'd1;
        chk($sformatf("rnd%0d_instret", idx), instret, exp_instret);
    endtask

    logic [6:0] pool[$];

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        set_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_outputs", obs(), E_FETCH_WAIT);
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        release_reset();

        vt.push_back(vec_t'{OP_LOAD,   3'b010, 1'b0, 1'b0, 1'b0, 5, 1, 1});
        vt.push_back(vec_t'{OP_STORE,  3'b010, 1'b0, 1'b0, 1'b0, 4, 1, 0});
        vt.push_back(vec_t'{OP_R,      3'b000, 1'b1, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back(vec_t'{OP_I,      3'b111, 1'b0, 1'b1, 1'b1, 4, 1, 1});
        vt.push_back(vec_t'{OP_LUI,    3'b000, 1'b0, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back(vec_t'{OP_AUIPC,  3'b000, 1'b0, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back(vec_t'{OP_JAL,    3'b000, 1'b0, 1'b0, 1'b0, 4, 2, 1});
        vt.push_back(vec_t'{OP_JALR,   3'b000, 1'b0, 1'b0, 1'b0, 5, 2, 1});
        vt.push_back(vec_t'{OP_BRANCH, 3'b000, 1'b1, 1'b0, 1'b0, 3, 2, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b0, 3, 1, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b001, 1'b1, 1'b0, 1'b0, 3, 1, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0, 3, 2, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b100, 1'b0, 1'b1, 1'b0, 3, 2, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b101, 1'b0, 1'b1, 1'b0, 3, 1, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b1, 3, 2, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b111, 1'b0, 1'b0, 1'b0, 3, 2, 0});
`ifndef MC_ILLEGAL_TRAP_EN
        vt.push_back(vec_t'{OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 3, 1, 0});
        vt.push_back(vec_t'{OP_BRANCH, 3'b011, 1'b0, 1'b0, 1'b0, 3, 1, 0});
        vt.push_back(vec_t'{7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 2, 1, 0});
`endif
        for (int k = 0; k < vt.size(); k++) run_vec(vt[k], k);

        set_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
        set_c(0, 1'b0, E_FETCH_WAIT); set_c(1, 1'b1, E_FETCH_RDY); set_c(2, 1'b0, E_DECODE);
        set_c(3, 1'b0, E_MEMADR_LD);  set_c(4, 1'b1, E_MEMREAD);   set_c(5, 1'b0, E_MEMWB);
        run_seq("lw", 6, 1);

        set_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b0, E_DECODE); set_c(2, 1'b0, E_MEMADR_ST);
        set_c(3, 1'b0, E_MEMWRITE);  set_c(4, 1'b0, E_MEMWRITE); set_c(5, 1'b0, E_MEMWRITE);
        set_c(6, 1'b1, E_MEMWRITE);
        run_seq("sw_wait", 7, 1);

        set_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0);
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b0, E_DECODE); set_c(2, 1'b1, E_JALR_ADR);
        set_c(3, 1'b0, E_JALR_JMP);  set_c(4, 1'b1, E_ALUWB);
        run_seq("jalr", 5, 1);

        set_instr(OP_BRANCH, 3'b001, 1'b1, 1'b0, 1'b0);
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b1, E_DECODE); set_c(2, 1'b1, E_BR_NT);
        run_seq("bne_nt", 3, 1);
        set_instr(OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0);
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b0, E_DECODE); set_c(2, 1'b0, E_BR_T);
        run_seq("bne_t", 3, 1);

        // Reset lands in MEMREAD with a read still pending.
        set_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        mem_ready = 1'b0;
        #1;
        chk("rst_mid_memread_before", obs(), E_MEMREAD);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", obs(), E_FETCH_WAIT);
        chk("rst_mid_instret", instret, 32'd0);
        exp_instret = 32'd0;
        release_reset();
        #1;
        chk("rst_mid_after_state", obs(), E_FETCH_WAIT);
        chk("rst_mid_after_instret", instret, 32'd0);

        pool = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
`ifndef MC_ILLEGAL_TRAP_EN
        pool.push_back(7'b0000000);
        pool.push_back(7'b1110011);
`endif
        for (int k = 0; k < 200; k++) run_random(k, pool[$urandom_range(0, pool.size() - 1)]);

        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b1, E_DECODE); set_c(2, 1'b1, E_ZERO);
        set_c(3, 1'b1, E_ZERO);      set_c(4, 1'b0, E_ZERO);
        run_seq("illegal_op", 5, 0);
        chk("illegal_op_flag", {31'd0, illegal}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("illegal_cleared", {31'd0, illegal}, 32'd0);
        exp_instret = 32'd0;
        release_reset();
        set_instr(OP_BRANCH, 3'b011, 1'b1, 1'b1, 1'b1);
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b1, E_DECODE); set_c(2, 1'b1, E_ZERO);
        set_c(3, 1'b1, E_ZERO);
        run_seq("illegal_br", 4, 0);
        chk("illegal_br_flag", {31'd0, illegal}, 32'd1);
`else
        set_c(0, 1'b1, E_FETCH_RDY); set_c(1, 1'b1, E_DECODE); set_c(2, 1'b0, E_FETCH_WAIT);
        run_seq("nop_op", 3, 1);
        chk("nop_illegal_flag", {31'd0, illegal}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I core. It steps a shared ALU, a single unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback. The block sits beside the datapath and drives every mux select and write enable each cycle. It handles variable-latency memory through a ready handshake and keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access requested
- mem_write  out  1  access is a store
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from Result
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- illegal  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, LUI, AUIPC, ALUWB, BRANCH, JAL, JALR_ADR, JALR_JMP, TRAP.
- Outputs are Moore from state, with two exceptions: `ir_write`/`pc_write` in FETCH are gated by `mem_ready`, and `pc_write` in BRANCH is gated by the taken condition. Any output not listed for a state is 0; `imm_src` is 000 unless listed.
- FETCH: mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10. ir_write = pc_write = mem_ready. Advance to DECODE on mem_ready, otherwise hold.
- DECODE: A=01, B=01, alu_op=00, imm_src=010. Computes the branch target into ALUOut.
- DECODE dispatches on op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - other → see Configuration
- MEMADR: A=10, B=01, alu_op=00, imm_src = 001 for store, 000 for load. Goes to MEMWRITE for store, MEMREAD for load.
- MEMREAD: mem_req=1, adr_src=1. Goes to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Goes to FETCH on mem_ready.
- EXEC_R: A=10, B=00, alu_op=10. Goes to ALUWB.
- EXEC_I: A=10, B=01, alu_op=10, imm_src=000. Goes to ALUWB.
- LUI: A=11, B=01, alu_op=00, imm_src=100. Goes to ALUWB.
- AUIPC: A=01, B=01, alu_op=00, imm_src=100. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- BRANCH: A=10, B=00, alu_op=01, result_src=00, pc_write=taken. Goes to FETCH.
  - taken by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 → 0.
- JAL: A=01, B=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
- JALR_ADR: A=10, B=01, alu_op=00, imm_src=000. Goes to JALR_JMP.
- JALR_JMP: A=01, B=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
- instret increments by 1 on every transition into FETCH from a non-FETCH, non-TRAP state. It wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync deassert by the system): state=FETCH, instret=0, illegal=0.
  - While in reset, outputs take FETCH values: mem_req=1, A=00, B=10, result_src=10, all write enables 0.
- Reset mid-instruction aborts immediately; no partial register write occurs after rst_n falls.
- Cycles per instruction with mem_ready held high:
  - branch 3
  - R/I/lui/auipc/jal/store 4
  - load/jalr 5
- Each low cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds one cycle. The state and all outputs hold stable while waiting.
- mem_ready is ignored in states with mem_req=0.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - Unknown opcode, or branch funct3 010/011, goes from DECODE to TRAP.
  - TRAP sets illegal=1 and holds all outputs 0 (mem_req=0) until reset.
  - instret does not increment.
- Undefined:
  - Unknown opcode goes from DECODE to FETCH as a NOP and counts as retired.
  - Branch funct3 010/011 is never taken.
  - illegal is tied 0.

## Test plan
- Reset during MEMREAD → next cycle state FETCH, reg_write=0, instret=0.
- lw with mem_ready=1 → 5 cycles; reg_write=1 with result_src=01 on cycle 5 only; instret +1.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write held 4 cycles, total 7 cycles, reg_write never 1.
- bne with zero=1 → pc_write=0 in BRANCH; with zero=0 → pc_write=1, result_src=00; bgeu with ltu=0 → taken.
- jalr → JALR_ADR(A=10, B=01) then JALR_JMP(pc_write=1) then ALUWB(reg_write=1); 5 cycles.
- op=0000000: with MC_ILLEGAL_TRAP_EN → illegal=1 from the cycle after DECODE, mem_req=0 thereafter, instret unchanged; without the macro → FETCH after DECODE, instret +1.
